// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 program sequencer: next-address select
// encoding and small helpers for the hardware loop counter.
package jtdsp16_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_JMP  = 3'd1,
    SEL_POP  = 3'd2,
    SEL_VEC  = 3'd3,
    SEL_PI   = 3'd4,
    SEL_LOOP = 3'd5
  } sel_e;

  localparam int unsigned LOOP_MIN_K = 2;

  // True when a count still needs at least one more pass through the body.
  function automatic logic loop_repeats(input logic [31:0] cnt);
    return cnt >= LOOP_MIN_K;
  endfunction

  function automatic logic loop_bad_len(input logic [31:0] ni);
    return ni == 32'd0;
  endfunction

endpackage

// File: rtl/jtdsp16_ret_stack.sv
// Return-address stack: circular buffer where a push into a full stack
// overwrites the oldest entry. Sticky overflow/underflow flags.
module jtdsp16_ret_stack #(
  parameter int AW = 12,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);

  localparam int PW = (SD > 1) ? $clog2(SD) : 1;
  localparam int CW = $clog2(SD + 1);

  logic [AW-1:0] mem_q [SD];
  logic [PW-1:0] wr_q, wr_d, wr_inc, top_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          full;

  assign full    = (cnt_q == CW'(SD));
  assign empty   = (cnt_q == '0);
  assign wr_inc  = (wr_q == PW'(SD - 1)) ? '0 : wr_q + 1'b1;
  assign top_idx = (wr_q == '0) ? PW'(SD - 1) : wr_q - 1'b1;
  assign top     = mem_q[top_idx];
  assign ovf     = ovf_q;
  assign udf     = udf_q;

  always_comb begin
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (push) begin
      // Pointer always advances; when full the count saturates so the
      // slot just overwritten was the oldest one.
      wr_d = wr_inc;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      if (empty) begin
        udf_d = 1'b1;
      end else begin
        wr_d  = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

endmodule

// File: rtl/jtdsp16_pc_seq.sv
// JTDSP16 program sequencer: PC with jumps, calls/returns, interrupt vector
// with dedicated return register, and a zero-overhead hardware do-loop.
module jtdsp16_pc_seq
  import jtdsp16_pkg::*;
#(
  parameter int            AW       = 12,
  parameter int            SD       = 4,
  parameter logic [AW-1:0] RST_ADDR = '0,
  parameter logic [AW-1:0] VEC      = {{(AW-1){1'b0}}, 1'b1},
  parameter int            KW       = 7,
  parameter int            NW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          goto_ja,
  input  logic          call_ja,
  input  logic          ret,
  input  logic          icall,
  input  logic          iret,
  input  logic [AW-1:0] ifield,
  input  logic          con_result,
  input  logic          do_en,
  input  logic [KW-1:0] do_k,
  input  logic [NW-1:0] do_ni,
  output logic [AW-1:0] rom_addr,
  output logic          in_loop,
  output logic          in_isr,
  output logic          stack_ovf,
  output logic          stack_udf,
  output logic          do_err
);

  logic [AW-1:0] pc_q, pc_d, pi_q, pi_d;
  logic [AW-1:0] lp_start_q, lp_start_d, lp_end_q, lp_end_d;
  logic [KW-1:0] lp_cnt_q, lp_cnt_d;
  logic          in_loop_q, in_loop_d, in_isr_q, in_isr_d, do_err_q, do_err_d;

  logic [AW-1:0] pc_inc, stk_top;
  logic          stk_empty, push, pop;
  logic          take_int, at_end, do_bad;
  sel_e          sel;

  assign pc_inc   = pc_q + 1'b1;
  assign take_int = icall && !in_isr_q && !in_loop_q;
  assign at_end   = in_loop_q && (pc_q == lp_end_q);
  assign do_bad   = in_loop_q || loop_bad_len(32'(do_ni));

  always_comb begin
    sel = SEL_SEQ;
    if (take_int)                                     sel = SEL_VEC;
    else if (iret)                                    sel = SEL_PI;
    else if (call_ja)                                 sel = SEL_JMP;
    else if (ret)                                     sel = SEL_POP;
    else if (goto_ja && con_result)                   sel = SEL_JMP;
    else if (at_end && loop_repeats(32'(lp_cnt_q)))   sel = SEL_LOOP;
  end

  assign push = cen && !take_int && !iret && call_ja;
  assign pop  = cen && (sel == SEL_POP);

  always_comb begin
    pc_d       = pc_q;
    pi_d       = pi_q;
    lp_start_d = lp_start_q;
    lp_end_d   = lp_end_q;
    lp_cnt_d   = lp_cnt_q;
    in_loop_d  = in_loop_q;
    in_isr_d   = in_isr_q;
    do_err_d   = do_err_q;
    if (cen) begin
      case (sel)
        SEL_VEC: begin
          pc_d     = VEC;
          pi_d     = pc_q;
          in_isr_d = 1'b1;
        end
        SEL_PI: begin
          pc_d     = pi_q;
          in_isr_d = 1'b0;
        end
        SEL_JMP:  pc_d = ifield;
        SEL_POP:  pc_d = stk_empty ? pc_inc : stk_top;
        SEL_LOOP: pc_d = lp_start_q;
        default:  pc_d = pc_inc;
      endcase

      // Any taken control transfer abandons a running loop.
      if (sel inside {SEL_PI, SEL_JMP, SEL_POP}) begin
        in_loop_d = 1'b0;
      end else if (at_end) begin
        if (sel == SEL_LOOP) lp_cnt_d = lp_cnt_q - 1'b1;
        else                 in_loop_d = 1'b0;
      end

      // A legal do only starts on plain sequential flow.
      if (do_en) begin
        if (do_bad) begin
          do_err_d = 1'b1;
        end else if (sel == SEL_SEQ) begin
          lp_start_d = pc_inc;
          lp_end_d   = pc_q + {{(AW-NW){1'b0}}, do_ni};
          lp_cnt_d   = do_k;
          in_loop_d  = loop_repeats(32'(do_k));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RST_ADDR;
      pi_q       <= '0;
      lp_start_q <= '0;
      lp_end_q   <= '0;
      lp_cnt_q   <= '0;
      in_loop_q  <= 1'b0;
      in_isr_q   <= 1'b0;
      do_err_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pi_q       <= pi_d;
      lp_start_q <= lp_start_d;
      lp_end_q   <= lp_end_d;
      lp_cnt_q   <= lp_cnt_d;
      in_loop_q  <= in_loop_d;
      in_isr_q   <= in_isr_d;
      do_err_q   <= do_err_d;
    end
  end

  jtdsp16_ret_stack #(
    .AW (AW),
    .SD (SD)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .empty (stk_empty),
    .ovf   (stack_ovf),
    .udf   (stack_udf)
  );

  assign rom_addr = pc_q;
  assign in_loop  = in_loop_q;
  assign in_isr   = in_isr_q;
  assign do_err   = do_err_q;

endmodule
